// File: rtl/bcd_time_counter_if.sv
// Set-port and display-digit bundle for bcd_time_counter.
// master: drives enable/set requests and observes the time digits and strobes.
// slave : the counter itself.
interface bcd_time_counter_if;
    logic       en;
    logic       set_load;
    logic [2:0] set_sel;
    logic [3:0] set_tens;
    logic [3:0] set_ones;
    logic       set_pm;

    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hr_ones;
    logic [1:0] hr_tens;
    logic       pm;
    logic       tick;
    logic       day_wrap;
    logic       set_err;
    logic       alarm_hit;

    modport master (
        output en, set_load, set_sel, set_tens, set_ones, set_pm,
        input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        input  pm, tick, day_wrap, set_err, alarm_hit
    );

    modport slave (
        input  en, set_load, set_sel, set_tens, set_ones, set_pm,
        output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        output pm, tick, day_wrap, set_err, alarm_hit
    );
endinterface

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with prescaler, 24h/12h hour modes,
// validated per-field set port and tick/day-wrap strobes.
// Optional alarm compare is built when BCD_TIME_ALARM_EN is defined;
// without it set_sel 3/4 are rejected and alarm_hit is tied low.
module bcd_time_counter #(
    parameter int unsigned DIV      = 50_000_000,
    parameter bit          MODE_12H = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bcd_time_counter_if.slave bus
);

    localparam int unsigned   PW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(DIV - 1);
    localparam logic [1:0]    HR_RST_TENS = MODE_12H ? 2'd1 : 2'd0;
    localparam logic [3:0]    HR_RST_ONES = MODE_12H ? 4'd2 : 4'd0;

    localparam logic [2:0] SEL_SEC  = 3'd0;
    localparam logic [2:0] SEL_MIN  = 3'd1;
    localparam logic [2:0] SEL_HOUR = 3'd2;
    localparam logic [2:0] SEL_AMIN = 3'd3;
    localparam logic [2:0] SEL_AHR  = 3'd4;

    logic [PW-1:0] presc_q;
    logic [3:0]    sec_ones_q, min_ones_q, hr_ones_q;
    logic [2:0]    sec_tens_q, min_tens_q;
    logic [1:0]    hr_tens_q;
    logic          pm_q;
    logic          tick_q, wrap_q, err_q;

    logic [3:0]    sec_ones_n, min_ones_n, hr_ones_n;
    logic [2:0]    sec_tens_n, min_tens_n;
    logic [1:0]    hr_tens_n;
    logic          pm_n;

    logic          field_ok_c;
    logic          load_c;
    logic          reject_c;
    logic          step_c;
    logic          day_end_c;
    logic          sec_max_c;
    logic          min_max_c;

    function automatic logic [7:0] bcd_val(input logic [3:0] tens, input logic [3:0] ones);
        return ({4'd0, tens} * 8'd10) + {4'd0, ones};
    endfunction

    // Seconds/minutes digits: 00..59
    function automatic logic sexa_ok(input logic [3:0] tens, input logic [3:0] ones);
        return (tens <= 4'd5) && (ones <= 4'd9);
    endfunction

    // Hour digits: 00..23 in 24h mode, 01..12 in 12h mode
    function automatic logic hour_ok(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] v;
        v = bcd_val(tens, ones);
        if ((tens > 4'd9) || (ones > 4'd9)) begin
            return 1'b0;
        end
        if (MODE_12H) begin
            return (v >= 8'd1) && (v <= 8'd12);
        end
        return (tens <= 4'd2) && (v <= 8'd23);
    endfunction

    // Set-port validation: field select and digit ranges
    always_comb begin
        field_ok_c = 1'b0;
        case (bus.set_sel)
            SEL_SEC, SEL_MIN: field_ok_c = sexa_ok(bus.set_tens, bus.set_ones);
            SEL_HOUR:         field_ok_c = hour_ok(bus.set_tens, bus.set_ones);
`ifdef BCD_TIME_ALARM_EN
            SEL_AMIN:         field_ok_c = sexa_ok(bus.set_tens, bus.set_ones);
            SEL_AHR:          field_ok_c = hour_ok(bus.set_tens, bus.set_ones);
`endif
            default:          field_ok_c = 1'b0;
        endcase
    end

    assign load_c    = bus.set_load & field_ok_c;
    assign reject_c  = bus.set_load & ~field_ok_c;
    // A valid load on the step edge discards the whole step
    assign step_c    = bus.en && (presc_q == PRE_LAST) && !load_c;
    assign sec_max_c = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
    assign min_max_c = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);

    // Next time value for a step: all carries resolve in one edge
    always_comb begin
        sec_ones_n = sec_ones_q;
        sec_tens_n = sec_tens_q;
        min_ones_n = min_ones_q;
        min_tens_n = min_tens_q;
        hr_ones_n  = hr_ones_q;
        hr_tens_n  = hr_tens_q;
        pm_n       = pm_q;
        day_end_c  = 1'b0;
        if (step_c) begin
            sec_ones_n = (sec_ones_q == 4'd9) ? 4'd0 : sec_ones_q + 4'd1;
            if (sec_ones_q == 4'd9) begin
                sec_tens_n = (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
            end
            if (sec_max_c) begin
                min_ones_n = (min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
                if (min_ones_q == 4'd9) begin
                    min_tens_n = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
                end
            end
            if (sec_max_c && min_max_c) begin
                if (MODE_12H) begin
                    if ((hr_tens_q == 2'd1) && (hr_ones_q == 4'd2)) begin
                        hr_tens_n = 2'd0;
                        hr_ones_n = 4'd1;
                    end else if ((hr_tens_q == 2'd1) && (hr_ones_q == 4'd1)) begin
                        hr_ones_n = 4'd2;
                        pm_n      = ~pm_q;
                        day_end_c = pm_q;
                    end else if (hr_ones_q == 4'd9) begin
                        hr_ones_n = 4'd0;
                        hr_tens_n = hr_tens_q + 2'd1;
                    end else begin
                        hr_ones_n = hr_ones_q + 4'd1;
                    end
                end else begin
                    if ((hr_tens_q == 2'd2) && (hr_ones_q == 4'd3)) begin
                        hr_tens_n = 2'd0;
                        hr_ones_n = 4'd0;
                        day_end_c = 1'b1;
                    end else if (hr_ones_q == 4'd9) begin
                        hr_ones_n = 4'd0;
                        hr_tens_n = hr_tens_q + 2'd1;
                    end else begin
                        hr_ones_n = hr_ones_q + 4'd1;
                    end
                end
            end
        end
    end

    // Prescaler, time registers and tick/day-wrap/set-error strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 3'd0;
            hr_ones_q  <= HR_RST_ONES;
            hr_tens_q  <= HR_RST_TENS;
            pm_q       <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tick_q <= step_c;
            wrap_q <= step_c & day_end_c;
            err_q  <= reject_c;
            if (load_c) begin
                presc_q <= '0;
                case (bus.set_sel)
                    SEL_SEC: begin
                        sec_tens_q <= 3'(bus.set_tens);
                        sec_ones_q <= bus.set_ones;
                    end
                    SEL_MIN: begin
                        min_tens_q <= 3'(bus.set_tens);
                        min_ones_q <= bus.set_ones;
                    end
                    SEL_HOUR: begin
                        hr_tens_q <= 2'(bus.set_tens);
                        hr_ones_q <= bus.set_ones;
                        pm_q      <= MODE_12H ? bus.set_pm : 1'b0;
                    end
                    default: begin
                    end
                endcase
            end else begin
                if (bus.en) begin
                    presc_q <= (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
                end
                sec_ones_q <= sec_ones_n;
                sec_tens_q <= sec_tens_n;
                min_ones_q <= min_ones_n;
                min_tens_q <= min_tens_n;
                hr_ones_q  <= hr_ones_n;
                hr_tens_q  <= hr_tens_n;
                pm_q       <= pm_n;
            end
        end
    end

`ifdef BCD_TIME_ALARM_EN
    logic [2:0] alm_min_tens_q;
    logic [3:0] alm_min_ones_q;
    logic [1:0] alm_hr_tens_q;
    logic [3:0] alm_hr_ones_q;
    logic       alm_pm_q;
    logic       hit_q;
    logic       alarm_match_c;

    // Alarm matches only when a step lands on HH:MM:00
    assign alarm_match_c = step_c
                        && (sec_ones_n == 4'd0) && (sec_tens_n == 3'd0)
                        && (min_ones_n == alm_min_ones_q) && (min_tens_n == alm_min_tens_q)
                        && (hr_ones_n == alm_hr_ones_q) && (hr_tens_n == alm_hr_tens_q)
                        && (pm_n == alm_pm_q);

    // Alarm registers and registered alarm strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            alm_min_tens_q <= 3'd0;
            alm_min_ones_q <= 4'd0;
            alm_hr_tens_q  <= HR_RST_TENS;
            alm_hr_ones_q  <= HR_RST_ONES;
            alm_pm_q       <= 1'b0;
            hit_q          <= 1'b0;
        end else begin
            hit_q <= alarm_match_c;
            if (load_c && (bus.set_sel == SEL_AMIN)) begin
                alm_min_tens_q <= 3'(bus.set_tens);
                alm_min_ones_q <= bus.set_ones;
            end
            if (load_c && (bus.set_sel == SEL_AHR)) begin
                alm_hr_tens_q <= 2'(bus.set_tens);
                alm_hr_ones_q <= bus.set_ones;
                alm_pm_q      <= MODE_12H ? bus.set_pm : 1'b0;
            end
        end
    end

    assign bus.alarm_hit = hit_q;
`else
    assign bus.alarm_hit = 1'b0;
`endif

    assign bus.sec_ones = sec_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.min_tens = min_tens_q;
    assign bus.hr_ones  = hr_ones_q;
    assign bus.hr_tens  = hr_tens_q;
    assign bus.pm       = pm_q;
    assign bus.tick     = tick_q;
    assign bus.day_wrap = wrap_q;
    assign bus.set_err  = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three instances (24h DIV=4, 12h DIV=4, 24h DIV=1)
// share one stimulus stream; a seconds-of-day reference model checks every cycle.
module tb_bcd_time_counter;

`ifdef BCD_TIME_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       set_load;
    logic [2:0] set_sel;
    logic [3:0] set_tens;
    logic [3:0] set_ones;
    logic       set_pm;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_time_counter_if if24 ();
    bcd_time_counter_if if12 ();
    bcd_time_counter_if if1  ();

    assign if24.en = en;  assign if24.set_load = set_load; assign if24.set_sel = set_sel;
    assign if24.set_tens = set_tens; assign if24.set_ones = set_ones; assign if24.set_pm = set_pm;
    assign if12.en = en;  assign if12.set_load = set_load; assign if12.set_sel = set_sel;
    assign if12.set_tens = set_tens; assign if12.set_ones = set_ones; assign if12.set_pm = set_pm;
    assign if1.en  = en;  assign if1.set_load  = set_load; assign if1.set_sel  = set_sel;
    assign if1.set_tens  = set_tens; assign if1.set_ones  = set_ones; assign if1.set_pm  = set_pm;

    bcd_time_counter #(.DIV(4), .MODE_12H(1'b0)) u24 (.clk(clk), .rst(rst), .bus(if24));
    bcd_time_counter #(.DIV(4), .MODE_12H(1'b1)) u12 (.clk(clk), .rst(rst), .bus(if12));
    bcd_time_counter #(.DIV(1), .MODE_12H(1'b0)) u1  (.clk(clk), .rst(rst), .bus(if1));

    // {sec_t, sec_o, min_t, min_o, hr_t, hr_o, pm, tick, day_wrap, set_err, alarm_hit}
    logic [24:0] obs [3];
    assign obs[0] = {if24.sec_tens, if24.sec_ones, if24.min_tens, if24.min_ones, if24.hr_tens,
                     if24.hr_ones, if24.pm, if24.tick, if24.day_wrap, if24.set_err, if24.alarm_hit};
    assign obs[1] = {if12.sec_tens, if12.sec_ones, if12.min_tens, if12.min_ones, if12.hr_tens,
                     if12.hr_ones, if12.pm, if12.tick, if12.day_wrap, if12.set_err, if12.alarm_hit};
    assign obs[2] = {if1.sec_tens, if1.sec_ones, if1.min_tens, if1.min_ones, if1.hr_tens,
                     if1.hr_ones, if1.pm, if1.tick, if1.day_wrap, if1.set_err, if1.alarm_hit};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: time kept as seconds since midnight, alarm as minute of day
    int mt [3];
    int mp [3];
    int malm [3];
    bit mtick [3];
    bit mwrap [3];
    bit merr [3];
    bit mhit [3];

    function automatic int div_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit mode_of(input int k);
        return (k == 1);
    endfunction

    function automatic bit load_valid(input int k, input int sel, input int tn, input int on);
        int v;
        v = tn * 10 + on;
        if (tn > 9 || on > 9) return 1'b0;
        if (sel == 0 || sel == 1 || (sel == 3 && ALM)) return (tn <= 5);
        if (sel == 2 || (sel == 4 && ALM)) return mode_of(k) ? (v >= 1 && v <= 12) : (v <= 23);
        return 1'b0;
    endfunction

    function automatic logic [24:0] model_pack(input int k);
        int h, m, s, hd;
        bit pmf;
        h   = mt[k] / 3600;
        m   = (mt[k] / 60) % 60;
        s   = mt[k] % 60;
        hd  = h;
        pmf = 1'b0;
        if (mode_of(k)) begin
            pmf = (h >= 12);
            hd  = h % 12;
            if (hd == 0) hd = 12;
        end
        return {3'(s / 10), 4'(s % 10), 3'(m / 10), 4'(m % 10), 2'(hd / 10), 4'(hd % 10),
                pmf, mtick[k], mwrap[k], merr[k], mhit[k]};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int  sel, tn, on, v, h24;
            bit  step;
            sel  = int'(set_sel);
            tn   = int'(set_tens);
            on   = int'(set_ones);
            v    = tn * 10 + on;
            h24  = mode_of(k) ? (v % 12 + (set_pm ? 12 : 0)) : v;
            step = en && (mp[k] == div_of(k) - 1);
            mtick[k] = 1'b0; mwrap[k] = 1'b0; merr[k] = 1'b0; mhit[k] = 1'b0;
            if (rst) begin
                mt[k] = 0; mp[k] = 0; malm[k] = 0;
            end else if (set_load && load_valid(k, sel, tn, on)) begin
                mp[k] = 0;
                case (sel)
                    0:       mt[k] = mt[k] - mt[k] % 60 + v;
                    1:       mt[k] = (mt[k] / 3600) * 3600 + v * 60 + mt[k] % 60;
                    2:       mt[k] = h24 * 3600 + mt[k] % 3600;
                    3:       malm[k] = (malm[k] / 60) * 60 + v;
                    default: malm[k] = h24 * 60 + malm[k] % 60;
                endcase
            end else begin
                merr[k] = set_load;
                if (en) mp[k] = (mp[k] + 1) % div_of(k);
                if (step) begin
                    mt[k]    = (mt[k] + 1) % 86400;
                    mtick[k] = 1'b1;
                    mwrap[k] = (mt[k] == 0);
                    mhit[k]  = ALM && (mt[k] % 60 == 0) && (mt[k] / 60 == malm[k]);
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // One clock: update the model at the edge, compare all instances just after it
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model dut%0d", k), 32'(obs[k]), 32'(model_pack(k)));
        end
    endtask

    task automatic load(input logic [2:0] sel, input logic [3:0] tn, input logic [3:0] on, input logic p);
        set_load = 1'b1; set_sel = sel; set_tens = tn; set_ones = on; set_pm = p;
        cycle();
        set_load = 1'b0;
    endtask

    task automatic wait_tick(input int k, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = obs[k][3];
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       pm;
        logic       err24;
        logic       err12;
    } vec_t;

    vec_t tbl [16];
    int   ticks;
    int   hits;

    initial begin
        tbl[0]  = '{3'd0, 4'd6, 4'd0,  1'b0, 1'b1, 1'b1};
        tbl[1]  = '{3'd0, 4'd5, 4'd9,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 4'd0, 4'd10, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{3'd1, 4'd5, 4'd9,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd1, 4'd7, 4'd0,  1'b0, 1'b1, 1'b1};
        tbl[5]  = '{3'd2, 4'd2, 4'd4,  1'b0, 1'b1, 1'b1};
        tbl[6]  = '{3'd2, 4'd2, 4'd3,  1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd2, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{3'd2, 4'd1, 4'd2,  1'b1, 1'b0, 1'b0};
        tbl[9]  = '{3'd2, 4'd1, 4'd3,  1'b0, 1'b0, 1'b1};
        tbl[10] = '{3'd6, 4'd0, 4'd0,  1'b0, 1'b1, 1'b1};
        tbl[11] = '{3'd3, 4'd1, 4'd5,  1'b0, !ALM, !ALM};
        tbl[12] = '{3'd4, 4'd0, 4'd7,  1'b0, !ALM, !ALM};
        tbl[13] = '{3'd4, 4'd2, 4'd4,  1'b0, 1'b1, 1'b1};
        tbl[14] = '{3'd7, 4'd1, 4'd1,  1'b0, 1'b1, 1'b1};
        tbl[15] = '{3'd2, 4'd0, 4'd10, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; en = 1'b0; set_load = 1'b0; set_sel = 3'd0;
        set_tens = 4'd0; set_ones = 4'd0; set_pm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mt[k] = 0; mp[k] = 0; malm[k] = 0;
            mtick[k] = 0; mwrap[k] = 0; merr[k] = 0; mhit[k] = 0;
        end
        cycle();
        cycle();
        chk("reset 24h", 32'(obs[0]), 32'd0);
        chk("reset 12h", 32'(obs[1]), 32'({3'd0, 4'd0, 3'd0, 4'd0, 2'd1, 4'd2, 1'b0, 4'b0000}));

        // Basic counting: 3 steps in 12 enabled cycles
        rst = 1'b0; en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (if24.tick) ticks++;
        end
        chk("t1 sec_ones", 32'(if24.sec_ones), 32'd3);
        chk("t1 tick count", 32'(ticks), 32'd3);

        // Set validation table, time frozen
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load(tbl[i].sel, tbl[i].tens, tbl[i].ones, tbl[i].pm);
            chk($sformatf("tbl%0d err24", i), 32'(if24.set_err), 32'(tbl[i].err24));
            chk($sformatf("tbl%0d err12", i), 32'(if12.set_err), 32'(tbl[i].err12));
        end
        cycle();
        chk("err clears", 32'(if24.set_err), 32'd0);

        // 24h day wrap
        load(3'd2, 4'd2, 4'd3, 1'b0);
        load(3'd1, 4'd5, 4'd9, 1'b0);
        load(3'd0, 4'd5, 4'd9, 1'b0);
        en = 1'b1;
        wait_tick(0, "t2 tick");
        chk("t2 time", 32'(obs[0][24:5]), 32'd0);
        chk("t2 day_wrap", 32'(if24.day_wrap), 32'd1);
        cycle();
        chk("t2 day_wrap pulse", 32'(if24.day_wrap), 32'd0);

        // 12h noon and midnight
        en = 1'b0;
        load(3'd2, 4'd1, 4'd1, 1'b0);
        load(3'd1, 4'd5, 4'd9, 1'b0);
        load(3'd0, 4'd5, 4'd9, 1'b0);
        en = 1'b1;
        wait_tick(1, "t3a tick");
        chk("t3a time", 32'(obs[1][24:4]), 32'({3'd0, 4'd0, 3'd0, 4'd0, 2'd1, 4'd2, 1'b1}));
        chk("t3a day_wrap", 32'(if12.day_wrap), 32'd0);
        en = 1'b0;
        load(3'd2, 4'd1, 4'd1, 1'b1);
        load(3'd1, 4'd5, 4'd9, 1'b0);
        load(3'd0, 4'd5, 4'd9, 1'b0);
        en = 1'b1;
        wait_tick(1, "t3b tick");
        chk("t3b time", 32'(obs[1][24:4]), 32'({3'd0, 4'd0, 3'd0, 4'd0, 2'd1, 4'd2, 1'b0}));
        chk("t3b day_wrap", 32'(if12.day_wrap), 32'd1);

        // Load on the step edge discards the step and restarts the prescaler
        en = 1'b0;
        load(3'd2, 4'd1, 4'd0, 1'b0);
        load(3'd1, 4'd2, 4'd9, 1'b0);
        load(3'd0, 4'd5, 4'd9, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 8 && mp[0] != 3; i++) cycle();
        chk("t5 reach step edge", 32'(mp[0]), 32'd3);
        load(3'd1, 4'd3, 4'd0, 1'b0);
        chk("t5 loaded", 32'(obs[0][24:3]), 32'({3'd5, 4'd9, 3'd3, 4'd0, 2'd1, 4'd0, 1'b0, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5 no early step", 32'({if24.sec_tens, if24.sec_ones, if24.tick}), 32'({3'd5, 4'd9, 1'b0}));
        end
        cycle();
        chk("t5 next step", 32'(obs[0][24:3]), 32'({3'd0, 4'd0, 3'd3, 4'd1, 2'd1, 4'd0, 1'b0, 1'b1}));

        // Alarm on the DIV=1 instance
        en = 1'b0;
        load(3'd3, 4'd1, 4'd5, 1'b0);
        chk("t6 sel3 err", 32'(if1.set_err), 32'(!ALM));
        load(3'd4, 4'd0, 4'd7, 1'b0);
        load(3'd2, 4'd0, 4'd7, 1'b0);
        load(3'd1, 4'd1, 4'd4, 1'b0);
        load(3'd0, 4'd5, 4'd8, 1'b0);
        en = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (if1.alarm_hit) begin
                hits++;
                chk("t6 hit time", 32'(obs[2][24:5]), 32'({3'd0, 4'd0, 3'd1, 4'd5, 2'd0, 4'd7}));
            end
        end
        chk("t6 hit count", 32'(hits), ALM ? 32'd1 : 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 499) == 0);
            en       = ($urandom_range(0, 9) < 8);
            set_load = ($urandom_range(0, 19) == 0);
            set_sel  = 3'($urandom_range(0, 7));
            set_tens = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            set_ones = 4'($urandom_range(0, 11));
            set_pm   = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b0; set_load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
